ubus_slave_responder: RTL and testbench



---
 rtl/ubus_rtl_pkg.sv | 35 +++
 rtl/ubus_slave_mem.sv | 36 +++
 rtl/ubus_slave_responder.sv | 169 ++++++++++++++++
 tb/tb_ubus_slave_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ubus_rtl_pkg.sv
// Shared UBus definitions for the slave responder RTL.
// Holds the bus widths, the transfer-size encodings, the responder FSM
// state type and the size-to-byte-count helper.
package ubus_rtl_pkg;

    localparam int unsigned UBUS_DATA_W = 8;
    localparam int unsigned UBUS_ADDR_W = 16;

    // sig_size encodings
    localparam logic [1:0] UBUS_SIZE_1 = 2'b00;
    localparam logic [1:0] UBUS_SIZE_2 = 2'b01;
    localparam logic [1:0] UBUS_SIZE_4 = 2'b10;
    localparam logic [1:0] UBUS_SIZE_8 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DATA  = 2'd2,
        ST_ERROR = 2'd3
    } ubus_slv_state_e;

    // Number of bytes moved by a transfer of the given size code.
    function automatic int ubus_size_to_bytes(input logic [1:0] size);
        int bytes;
        case (size)
            UBUS_SIZE_1: bytes = 1;
            UBUS_SIZE_2: bytes = 2;
            UBUS_SIZE_4: bytes = 4;
            UBUS_SIZE_8: bytes = 8;
            default:     bytes = 1;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/ubus_slave_mem.sv
// Byte-wide storage window for the UBus slave.
// Ports: clk; we/waddr/wdata synchronous write; re/raddr load rdata
// register on the rising edge (registered read). No reset: contents and
// the read register survive bus resets.
module ubus_slave_mem
    import ubus_rtl_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    localparam int unsigned AW = $clog2(MEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [UBUS_DATA_W-1:0] wdata,
    input  logic                   re,
    input  logic [AW-1:0]          raddr,
    output logic [UBUS_DATA_W-1:0] rdata
);

    logic [UBUS_DATA_W-1:0] mem [MEM_DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ubus_slave_responder.sv
// UBus slave responder: claims [ADDR_BASE, ADDR_BASE+MEM_DEPTH-1], answers
// reads/writes of 1/2/4/8 bytes from a local byte memory, inserting
// WAIT_STATES wait cycles before every byte.
// Ports:
//   sig_clock, sig_reset      clock, async active-high reset
//   sig_start/addr/size       address phase (valid when sig_start=1)
//   sig_read/sig_write        transfer direction
//   sig_bip                   burst-in-progress (sampled, not used)
//   sig_data_in               write data from master
//   sig_data_out/sig_data_oe  read data and its drive enable
//   sig_wait, sig_error       slave wait request, error response
module ubus_slave_responder
    import ubus_rtl_pkg::*;
#(
    parameter logic [UBUS_ADDR_W-1:0] ADDR_BASE   = 16'h0000,
    parameter int unsigned            MEM_DEPTH   = 256,
    parameter int unsigned            WAIT_STATES = 0
) (
    input  logic                   sig_clock,
    input  logic                   sig_reset,
    input  logic                   sig_start,
    input  logic [UBUS_ADDR_W-1:0] sig_addr,
    input  logic [1:0]             sig_size,
    input  logic                   sig_read,
    input  logic                   sig_write,
    input  logic                   sig_bip,
    input  logic [UBUS_DATA_W-1:0] sig_data_in,
    output logic [UBUS_DATA_W-1:0] sig_data_out,
    output logic                   sig_data_oe,
    output logic                   sig_wait,
    output logic                   sig_error
);

    localparam int unsigned OFF_W   = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned BYTES_W = 4;
    localparam int unsigned REL_W   = UBUS_ADDR_W + 1;
    localparam logic [CNT_W-1:0] WAIT_RELOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
    localparam logic [REL_W-1:0] DEPTH_EXT = REL_W'(MEM_DEPTH);

    ubus_slv_state_e        state_q, state_d;
    logic [OFF_W-1:0]       offset_q, offset_d;
    logic [BYTES_W-1:0]     bytes_q, bytes_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dir_rd_q, dir_rd_d;
    logic                   wait_d, error_d, oe_d;
    logic                   wait_q, error_q, oe_q;
    logic                   mem_we_c;
    logic                   mem_re_c;
    logic [REL_W-1:0]       rel_addr_c;
    logic                   selected_c;
    logic [UBUS_DATA_W-1:0] mem_rdata;

    // Burst-in-progress carries no information the slave needs.
    logic unused_bip;
    assign unused_bip = sig_bip;

    // Address decode; extra bit keeps ADDR_BASE+MEM_DEPTH from overflowing.
    assign rel_addr_c = REL_W'(sig_addr) - REL_W'(ADDR_BASE);
    assign selected_c = (sig_addr >= ADDR_BASE) && (rel_addr_c < DEPTH_EXT);

    // State and registered outputs
    always_ff @(posedge sig_clock or posedge sig_reset) begin
        if (sig_reset) begin
            state_q  <= ST_IDLE;
            offset_q <= '0;
            bytes_q  <= '0;
            cnt_q    <= '0;
            dir_rd_q <= 1'b0;
            wait_q   <= 1'b0;
            error_q  <= 1'b0;
            oe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            bytes_q  <= bytes_d;
            cnt_q    <= cnt_d;
            dir_rd_q <= dir_rd_d;
            wait_q   <= wait_d;
            error_q  <= error_d;
            oe_q     <= oe_d;
        end
    end

    // Next-state, counters and next output values
    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        bytes_d  = bytes_q;
        cnt_d    = cnt_q;
        dir_rd_d = dir_rd_q;
        mem_we_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sig_start && selected_c) begin
                    if (sig_read && sig_write) begin
                        state_d = ST_ERROR;
                    end else if (sig_read ^ sig_write) begin
                        offset_d = rel_addr_c[OFF_W-1:0];
                        bytes_d  = BYTES_W'(ubus_size_to_bytes(sig_size));
                        dir_rd_d = sig_read;
                        if (WAIT_STATES > 0) begin
                            state_d = ST_WAIT;
                            cnt_d   = WAIT_RELOAD;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DATA: begin
                mem_we_c = ~dir_rd_q;
                if (bytes_q > BYTES_W'(1)) begin
                    bytes_d  = bytes_q - 1'b1;
                    // Offset wraps naturally at the window top.
                    offset_d = offset_q + 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_RELOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wait_d   = (state_d == ST_WAIT);
        error_d  = (state_d == ST_ERROR);
        oe_d     = (state_d == ST_DATA) && dir_rd_d;
        // Read register loads on the edge entering each read DATA cycle.
        mem_re_c = oe_d;
    end

    ubus_slave_mem #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (sig_clock),
        .we    (mem_we_c),
        .waddr (offset_q),
        .wdata (sig_data_in),
        .re    (mem_re_c),
        .raddr (offset_d),
        .rdata (mem_rdata)
    );

    // Memory read register is not reset, so gate it with the reset-cleared enable.
    assign sig_data_out = oe_q ? mem_rdata : '0;
    assign sig_data_oe  = oe_q;
    assign sig_wait     = wait_q;
    assign sig_error    = error_q;

endmodule

// File: tb/tb_ubus_slave_responder.sv
// Bench for ubus_slave_responder: two instances (0 and 2 wait states)
// share the bus inputs but have separate start strobes. A transaction-level
// model expands each accepted address phase into the per-cycle response the
// bus rules require and is compared on every falling clock edge.
module tb_ubus_slave_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned BASE  = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] addr = '0;
    logic [1:0]  size = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic        bip = 1'b0;
    logic [7:0]  din = '0;

    logic [7:0]  dout0, dout1;
    logic        oe0, oe1, wt0, wt1, er0, er1;

    always #5 clk = ~clk;

    ubus_slave_responder #(
        .ADDR_BASE   (16'h0000),
        .MEM_DEPTH   (DEPTH),
        .WAIT_STATES (0)
    ) u_dut0 (
        .sig_clock    (clk),
        .sig_reset    (rst),
        .sig_start    (start0),
        .sig_addr     (addr),
        .sig_size     (size),
        .sig_read     (rd),
        .sig_write    (wr),
        .sig_bip      (bip),
        .sig_data_in  (din),
        .sig_data_out (dout0),
        .sig_data_oe  (oe0),
        .sig_wait     (wt0),
        .sig_error    (er0)
    );

    ubus_slave_responder #(
        .ADDR_BASE   (16'h0000),
        .MEM_DEPTH   (DEPTH),
        .WAIT_STATES (2)
    ) u_dut2 (
        .sig_clock    (clk),
        .sig_reset    (rst),
        .sig_start    (start1),
        .sig_addr     (addr),
        .sig_size     (size),
        .sig_read     (rd),
        .sig_write    (wr),
        .sig_bip      (bip),
        .sig_data_in  (din),
        .sig_data_out (dout1),
        .sig_data_oe  (oe1),
        .sig_wait     (wt1),
        .sig_error    (er1)
    );

    typedef struct {
        bit w;
        bit e;
        bit d;
        bit wrb;
        int off;
    } ent_t;

    ent_t        q [2][$];
    logic [7:0]  mm [2][DEPTH];
    bit          mk [2][DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle reference: expected outputs derived from the transfer rules.
    always @(negedge clk) begin
        logic [7:0] o_d;
        logic       o_oe, o_w, o_e, st;
        int         ws, nb, rel;
        bit         sel;
        ent_t       en;
        for (int k = 0; k < 2; k++) begin
            o_d  = (k == 0) ? dout0 : dout1;
            o_oe = (k == 0) ? oe0 : oe1;
            o_w  = (k == 0) ? wt0 : wt1;
            o_e  = (k == 0) ? er0 : er1;
            st   = (k == 0) ? start0 : start1;
            ws   = (k == 0) ? 0 : 2;
            if (rst) begin
                q[k].delete();
                chk($sformatf("d%0d_reset_outs", k), {o_w, o_e, o_oe, o_d}, 0);
            end else if (q[k].size() == 0) begin
                chk($sformatf("d%0d_idle_outs", k), {o_w, o_e, o_oe, o_d}, 0);
                if (st) begin
                    rel = int'(addr) - int'(BASE);
                    sel = (rel >= 0) && (rel < int'(DEPTH));
                    nb  = 1 << size;
                    if (sel && rd && wr) begin
                        q[k].push_back('{w: 1'b0, e: 1'b1, d: 1'b0, wrb: 1'b0, off: 0});
                    end else if (sel && (rd != wr)) begin
                        for (int i = 0; i < nb; i++) begin
                            for (int j = 0; j < ws; j++)
                                q[k].push_back('{w: 1'b1, e: 1'b0, d: 1'b0, wrb: 1'b0, off: 0});
                            q[k].push_back('{w: 1'b0, e: 1'b0, d: 1'b1, wrb: wr,
                                             off: (rel + i) % int'(DEPTH)});
                        end
                    end
                end
            end else begin
                en = q[k].pop_front();
                chk($sformatf("d%0d_wait", k), o_w, en.w);
                chk($sformatf("d%0d_error", k), o_e, en.e);
                chk($sformatf("d%0d_oe", k), o_oe, en.d && !en.wrb);
                if (en.d && !en.wrb && mk[k][en.off])
                    chk($sformatf("d%0d_rdata@%0h", k, en.off), o_d, mm[k][en.off]);
                if (en.d && en.wrb) begin
                    mm[k][en.off] = din;
                    mk[k][en.off] = 1'b1;
                end
            end
        end
    end

    // Entered at posedge+1; returns at posedge+1 of the first idle cycle.
    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk); #1;
        while ((q[0].size() != 0 || q[1].size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait_bound", 32'(n < 300), 1);
    endtask

    // Address phase in cycle T; returns in cycle T+1 (posedge+1).
    task automatic start_xfer(input int k, input logic [15:0] a, input logic [1:0] s,
                              input logic r, input logic w, input logic [7:0] d0);
        wait_idle();
        addr = a; size = s; rd = r; wr = w; din = d0; bip = (s != 2'b00);
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0;
    endtask

    logic [7:0] wb [8];
    logic [7:0] exp4 [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset asserted mid-idle clears outputs at once
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_idle_d0", {wt0, er0, oe0, dout0}, 0);
        chk("rst_idle_d2", {wt1, er1, oe1, dout1}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // No-wait single-byte write then read-back
        start_xfer(0, 16'h0010, 2'b00, 1'b0, 1'b1, 8'hA5);
        chk("ws0_wr_nowait", wt0, 0);
        chk("ws0_wr_nooe", oe0, 0);
        start_xfer(0, 16'h0010, 2'b00, 1'b1, 1'b0, 8'h00);
        chk("ws0_rd_data", dout0, 8'hA5);
        chk("ws0_rd_oe", oe0, 1);
        chk("ws0_rd_nowait", wt0, 0);
        @(posedge clk); #1;
        chk("ws0_rd_oe_drop", oe0, 0);
        chk("ws0_rd_data_drop", dout0, 0);

        // Two wait states, 4-byte write wrapping past the window top
        wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33; wb[3] = 8'h44;
        start_xfer(1, 16'h00FE, 2'b10, 1'b0, 1'b1, wb[0]);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                din = wb[i];
                chk($sformatf("ws2_wr_wait_b%0d_c%0d", i, j), wt1, 32'(j < 2));
                @(posedge clk); #1;
            end
        end
        exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
        start_xfer(1, 16'h00FE, 2'b10, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (j == 2) begin
                    chk($sformatf("ws2_rd_b%0d", i), dout1, exp4[i]);
                    chk($sformatf("ws2_rd_oe_b%0d", i), oe1, 1);
                end else begin
                    chk($sformatf("ws2_rd_wait_b%0d_c%0d", i, j), wt1, 1);
                end
                @(posedge clk); #1;
            end
        end

        // Out-of-range write is ignored, offset 0 unchanged
        start_xfer(1, 16'h0200, 2'b00, 1'b0, 1'b1, 8'hEE);
        chk("oor_outs_t1", {wt1, er1, oe1}, 0);
        @(posedge clk); #1;
        chk("oor_outs_t2", {wt1, er1, oe1}, 0);
        start_xfer(1, 16'h0000, 2'b00, 1'b1, 1'b0, 8'h00);
        repeat (2) begin @(posedge clk); #1; end
        chk("oor_rd0_data", dout1, 8'h33);
        chk("oor_rd0_oe", oe1, 1);

        // Read+write together: one-cycle error, memory untouched
        start_xfer(0, 16'h0020, 2'b00, 1'b0, 1'b1, 8'h5A);
        start_xfer(0, 16'h0020, 2'b00, 1'b1, 1'b1, 8'hC3);
        chk("err_t1", er0, 1);
        chk("err_t1_wait", wt0, 0);
        chk("err_t1_oe", oe0, 0);
        @(posedge clk); #1;
        chk("err_t2", er0, 0);
        start_xfer(0, 16'h0020, 2'b00, 1'b1, 1'b0, 8'h00);
        chk("err_mem_kept", dout0, 8'h5A);

        // Two-byte wrap on the no-wait slave, checked by the model
        start_xfer(0, 16'h00FF, 2'b01, 1'b0, 1'b1, 8'h9C);
        din = 8'h9C; @(posedge clk); #1;
        din = 8'h6D; @(posedge clk); #1;
        start_xfer(0, 16'h00FF, 2'b01, 1'b1, 1'b0, 8'h00);

        // 8-byte burst, reset during byte 2 of the read-back
        for (int i = 0; i < 8; i++) wb[i] = 8'(i + 1);
        start_xfer(0, 16'h0010, 2'b11, 1'b0, 1'b1, wb[0]);
        for (int i = 0; i < 8; i++) begin
            din = wb[i];
            @(posedge clk); #1;
        end
        start_xfer(0, 16'h0010, 2'b11, 1'b1, 1'b0, 8'h00);
        chk("burst_b1", dout0, 8'h01);
        @(posedge clk); #1;
        chk("burst_b2", dout0, 8'h02);
        #1 rst = 1'b1;
        #1;
        chk("burst_rst_outs", {wt0, er0, oe0, dout0}, 0);
        @(posedge clk); #1 rst = 1'b0;
        start_xfer(0, 16'h0010, 2'b00, 1'b1, 1'b0, 8'h00);
        chk("post_rst_rd", dout0, 8'h01);
        chk("post_rst_oe", oe0, 1);

        wait_idle();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
